// File: rtl/set_sched_pkg.sv
// Shared types and widths for the SET job scheduler: FSM encoding, job field
// widths and the engine mode codes used by clients.
package set_sched_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_RUN    = 2'd2,
        S_RESP   = 2'd3
    } sched_state_t;

    localparam int CENTRAL_W = 24;
    localparam int RADIUS_W  = 12;
    localparam int MODE_W    = 2;
    localparam int CAND_W    = 8;

    localparam logic [MODE_W-1:0] MODE_A            = 2'd0;
    localparam logic [MODE_W-1:0] MODE_AND          = 2'd1;
    localparam logic [MODE_W-1:0] MODE_XOR          = 2'd2;
    localparam logic [MODE_W-1:0] MODE_TWO_OF_THREE = 2'd3;

endpackage

// File: rtl/set_job_scheduler_rr_arbiter.sv
// Combinational round-robin picker: grants the first requester at or after ptr,
// wrapping from NREQ-1 back to 0. Grants nothing unless advance is high.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    input  logic            advance,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_id
);

    logic           found;
    logic [IDW-1:0] idx;

    // NOTE: every variable driven here gets a default before the loop, so no latch is inferred.
    always_comb begin
        grant    = '0;
        grant_id = '0;
        found    = 1'b0;
        idx      = '0;
        for (int off = 0; off < NREQ; off++) begin
            idx = IDW'((int'(ptr) + off) % NREQ);
            if (advance && !found && req[idx]) begin
                grant[idx] = 1'b1;
                grant_id   = idx;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/set_job_scheduler.sv
// Time-shares one SET point-counting engine between NREQ requesters: round-robin
// grant, one-cycle launch, wait for the result (or watchdog abort), tagged response.
module set_job_scheduler
    import set_sched_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int IDW     = 2,
    parameter int TIMEOUT = 100
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*CENTRAL_W-1:0] job_central,
    input  logic [NREQ*RADIUS_W-1:0] job_radius,
    input  logic [NREQ*MODE_W-1:0]   job_mode,
    output logic [NREQ-1:0]          gnt,
    output logic                     rsp_valid,
    output logic [IDW-1:0]           rsp_id,
    output logic [CAND_W-1:0]        rsp_candidate,
    output logic                     rsp_err,
    output logic                     sched_busy,
    output logic                     eng_en,
    output logic [CENTRAL_W-1:0]     eng_central,
    output logic [RADIUS_W-1:0]      eng_radius,
    output logic [MODE_W-1:0]        eng_mode,
    input  logic                     eng_busy,
    input  logic                     eng_valid,
    input  logic [CAND_W-1:0]        eng_candidate
);

    localparam int WD_W = $clog2(TIMEOUT);

    sched_state_t    state_q, state_d;
    logic [IDW-1:0]  rr_ptr;
    logic [WD_W-1:0] wd_q;
    logic            wd_expire;
    logic            arb_adv;
    logic [NREQ-1:0] arb_gnt;
    logic [IDW-1:0]  arb_id;
    logic            eng_busy_unused;

    logic [CENTRAL_W-1:0] central_arr [NREQ];
    logic [RADIUS_W-1:0]  radius_arr  [NREQ];
    logic [MODE_W-1:0]    mode_arr    [NREQ];

    assign eng_busy_unused = eng_busy;

    for (genvar g = 0; g < NREQ; g++) begin : g_slice
        assign central_arr[g] = job_central[g*CENTRAL_W +: CENTRAL_W];
        assign radius_arr[g]  = job_radius[g*RADIUS_W +: RADIUS_W];
        assign mode_arr[g]    = job_mode[g*MODE_W +: MODE_W];
    end

    rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
        .req      (req),
        .ptr      (rr_ptr),
        .advance  (arb_adv),
        .grant    (arb_gnt),
        .grant_id (arb_id)
    );

    // The timeout fires on the cycle the incremented count reaches TIMEOUT-1,
    // which puts the abort response exactly TIMEOUT cycles after eng_en.
    assign wd_expire  = (wd_q == WD_W'(TIMEOUT - 2));
    assign sched_busy = (state_q != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        arb_adv   = 1'b0;
        gnt       = '0;
        eng_en    = 1'b0;
        rsp_valid = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                // Gated by rst_n so a held request cannot show a grant while in reset.
                arb_adv = rst_n;
                gnt     = arb_gnt;
                if (|arb_gnt) state_d = S_LAUNCH;
            end
            S_LAUNCH: begin
                eng_en  = 1'b1;
                state_d = S_RUN;
            end
            S_RUN: begin
                if (eng_valid || wd_expire) state_d = S_RESP;
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: all sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr        <= '0;
            wd_q          <= '0;
            eng_central   <= '0;
            eng_radius    <= '0;
            eng_mode      <= '0;
            rsp_id        <= '0;
            rsp_candidate <= '0;
            rsp_err       <= 1'b0;
        end else begin
            if (state_q == S_IDLE && |arb_gnt) begin
                eng_central <= central_arr[arb_id];
                eng_radius  <= radius_arr[arb_id];
                eng_mode    <= mode_arr[arb_id];
                rsp_id      <= arb_id;
                rr_ptr      <= (arb_id == IDW'(NREQ - 1)) ? '0 : arb_id + 1'b1;
            end
            if (state_q == S_LAUNCH)   wd_q <= '0;
            else if (state_q == S_RUN) wd_q <= wd_q + 1'b1;
            if (state_q == S_RUN) begin
                if (eng_valid) begin
                    rsp_candidate <= eng_candidate;
                    rsp_err       <= 1'b0;
                end else if (wd_expire) begin
                    rsp_candidate <= '0;
                    rsp_err       <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_set_job_scheduler.sv
// Self-checking bench for set_job_scheduler: the bench plays both the clients and
// the SET engine and predicts grant order, launch data and response timing per job.
module tb_set_job_scheduler;

    localparam int NREQ    = 4;
    localparam int IDW     = 2;
    localparam int TIMEOUT = 100;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req;
    logic [NREQ*24-1:0] job_central;
    logic [NREQ*12-1:0] job_radius;
    logic [NREQ*2-1:0] job_mode;
    logic [NREQ-1:0]   gnt;
    logic              rsp_valid;
    logic [IDW-1:0]    rsp_id;
    logic [7:0]        rsp_candidate;
    logic              rsp_err;
    logic              sched_busy;
    logic              eng_en;
    logic [23:0]       eng_central;
    logic [11:0]       eng_radius;
    logic [1:0]        eng_mode;
    logic              eng_busy;
    logic              eng_valid;
    logic [7:0]        eng_candidate;

    logic [23:0] cen  [NREQ];
    logic [11:0] rad  [NREQ];
    logic [1:0]  mde  [NREQ];

    int n_checks = 0;
    int n_errors = 0;
    int m_ptr    = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NREQ; g++) begin : g_pack
        assign job_central[g*24 +: 24] = cen[g];
        assign job_radius[g*12 +: 12]  = rad[g];
        assign job_mode[g*2 +: 2]      = mde[g];
    end

    set_job_scheduler #(.NREQ(NREQ), .IDW(IDW), .TIMEOUT(TIMEOUT)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req           (req),
        .job_central   (job_central),
        .job_radius    (job_radius),
        .job_mode      (job_mode),
        .gnt           (gnt),
        .rsp_valid     (rsp_valid),
        .rsp_id        (rsp_id),
        .rsp_candidate (rsp_candidate),
        .rsp_err       (rsp_err),
        .sched_busy    (sched_busy),
        .eng_en        (eng_en),
        .eng_central   (eng_central),
        .eng_radius    (eng_radius),
        .eng_mode      (eng_mode),
        .eng_busy      (eng_busy),
        .eng_valid     (eng_valid),
        .eng_candidate (eng_candidate)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Requester search order: lowest index at or above the pointer, otherwise the lowest overall.
    function automatic int rr_pick(input logic [NREQ-1:0] r, input int p);
        for (int i = p; i < NREQ; i++) if (r[i]) return i;
        for (int i = 0; i < p; i++) if (r[i]) return i;
        return -1;
    endfunction

    task automatic randomize_jobs();
        for (int i = 0; i < NREQ; i++) begin
            cen[i] = 24'($urandom);
            rad[i] = 12'($urandom);
            mde[i] = 2'($urandom);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_gnt"},     32'(gnt), 32'd0);
        check({tag, "_rsp_v"},   32'(rsp_valid), 32'd0);
        check({tag, "_rsp_id"},  32'(rsp_id), 32'd0);
        check({tag, "_rsp_c"},   32'(rsp_candidate), 32'd0);
        check({tag, "_rsp_e"},   32'(rsp_err), 32'd0);
        check({tag, "_busy"},    32'(sched_busy), 32'd0);
        check({tag, "_eng_en"},  32'(eng_en), 32'd0);
        check({tag, "_eng_cen"}, 32'(eng_central), 32'd0);
        check({tag, "_eng_rad"}, 32'(eng_radius), 32'd0);
        check({tag, "_eng_mod"}, 32'(eng_mode), 32'd0);
    endtask

    // One complete job. lat = cycles from eng_en to the engine's eng_valid pulse; lat < 1 means never.
    task automatic run_job(input logic [NREQ-1:0] reqs, input int lat, input logic [7:0] cand);
        int         exp_id, exp_k, k;
        bit         seen;
        logic [7:0] exp_cand;
        logic       exp_err;
        exp_id = rr_pick(reqs, m_ptr);
        req = reqs;
        #1;
        k = 0;
        while (gnt == '0 && k < 8) begin
            tick();
            #1;
            k++;
        end
        check("gnt", 32'(gnt), 32'd1 << exp_id);
        tick();
        req = '0;
        check("eng_en", 32'(eng_en), 32'd1);
        check("eng_central", 32'(eng_central), 32'(cen[exp_id]));
        check("eng_radius", 32'(eng_radius), 32'(rad[exp_id]));
        check("eng_mode", 32'(eng_mode), 32'(mde[exp_id]));
        check("busy_launch", 32'(sched_busy), 32'd1);
        m_ptr = (exp_id + 1) % NREQ;
        if (lat > 0 && lat <= TIMEOUT - 1) begin
            exp_k = lat + 1;  exp_cand = cand;  exp_err = 1'b0;
        end else begin
            exp_k = TIMEOUT;  exp_cand = 8'd0;  exp_err = 1'b1;
        end
        seen = 1'b0;
        k = 0;
        while (!seen && k < TIMEOUT + 10) begin
            tick();
            k++;
            eng_valid     = (k == lat);
            eng_candidate = (k == lat) ? cand : 8'($urandom);
            eng_busy      = (k < lat);
            #1;
            if (k == 1) check("eng_en_pulse", 32'(eng_en), 32'd0);
            if (rsp_valid) seen = 1'b1;
        end
        eng_valid = 1'b0;
        eng_busy  = 1'b0;
        check("rsp_seen", 32'(seen), 32'd1);
        check("rsp_cycle", 32'(k), 32'(exp_k));
        check("rsp_id", 32'(rsp_id), 32'(exp_id));
        check("rsp_candidate", 32'(rsp_candidate), 32'(exp_cand));
        check("rsp_err", 32'(rsp_err), 32'(exp_err));
        tick();
        check("rsp_pulse", 32'(rsp_valid), 32'd0);
        check("idle_after", 32'(sched_busy), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int k;
        int sel;
        int lat;
        rst_n         = 1'b0;
        req           = '0;
        eng_valid     = 1'b0;
        eng_busy      = 1'b0;
        eng_candidate = '0;
        randomize_jobs();
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Fairness from reset: all requests held gives 0,1,2,3,0.
        for (int j = 0; j < 5; j++) begin
            randomize_jobs();
            run_job(4'b1111, 66, 8'($urandom));
        end

        // Single directed job for requester 1.
        randomize_jobs();
        cen[1] = 24'h34_45_56;
        rad[1] = 12'h333;
        mde[1] = 2'd0;
        run_job(4'b0010, 66, 8'd29);

        // Pointer wrap around the top requester.
        run_job(4'b1000, 66, 8'($urandom));
        run_job(4'b1001, 66, 8'($urandom));
        run_job(4'b1001, 66, 8'($urandom));

        // Watchdog abort, then a normal job, then the valid-vs-timeout race.
        randomize_jobs();
        run_job(4'b0100, -1, 8'hAA);
        run_job(4'b0100, 66, 8'd17);
        run_job(4'b0001, TIMEOUT - 1, 8'hC3);
        run_job(4'b0010, TIMEOUT - 2, 8'h5A);

        // Stray engine pulses while idle must not produce a response.
        for (int j = 0; j < 3; j++) begin
            eng_valid     = 1'b1;
            eng_candidate = 8'($urandom);
            #1;
            check("stray_rsp", 32'(rsp_valid), 32'd0);
            tick();
            eng_valid = 1'b0;
            check("stray_busy", 32'(sched_busy), 32'd0);
        end

        // Randomized traffic.
        for (int j = 0; j < 20; j++) begin
            randomize_jobs();
            sel = $urandom_range(0, 9);
            if (sel == 0)      lat = -1;
            else if (sel == 1) lat = TIMEOUT - 1;
            else if (sel == 2) lat = 66;
            else               lat = $urandom_range(1, TIMEOUT - 2);
            run_job(4'($urandom_range(1, 15)), lat, 8'($urandom));
        end

        // Reset in the middle of RUN drops the job without a response.
        randomize_jobs();
        req = 4'b1111;
        #1;
        k = 0;
        while (gnt == '0 && k < 8) begin
            tick();
            #1;
            k++;
        end
        check("rst_job_gnt", 32'(gnt), 32'd1 << rr_pick(4'b1111, m_ptr));
        repeat (11) tick();
        check("rst_job_running", 32'(sched_busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("rst_async");
        tick();
        check_zero("rst_held");
        req = '0;
        m_ptr = 0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int j = 1; j <= 6; j++) begin
            tick();
            eng_valid     = (j == 2);
            eng_candidate = 8'($urandom);
            #1;
            check("rst_no_rsp", 32'(rsp_valid), 32'd0);
        end
        eng_valid = 1'b0;
        randomize_jobs();
        run_job(4'b1111, 66, 8'($urandom));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
